// File: rtl/inst_fetch_resp.sv
// Byte-serial instruction fetch: reads four consecutive bytes from a byte-wide RAM and
// assembles a little-endian 32-bit word. Optional last-fetch buffer: define IF_LAST_HIT_EN.
module inst_fetch_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    output logic [31:0] mem_a,
    input  logic [7:0]  mem_din,
    output logic        mem_wr,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        busy_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  cnt_inc;
    logic [31:0] addr_q, addr_d;
    logic [23:0] cap_q, cap_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        lb_hit;

`ifdef IF_LAST_HIT_EN
    logic [31:0] lb_tag_q, lb_tag_d;
    logic [31:0] lb_data_q, lb_data_d;
    logic        lb_valid_q, lb_valid_d;
    logic        hit_pend_q, hit_pend_d;

    assign lb_hit = lb_valid_q && (pc_i == lb_tag_q);
`else
    assign lb_hit = 1'b0;
`endif

    assign cnt_inc = cnt_q + 2'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        cap_d   = cap_q;
        mem_a_d = mem_a_q;
        inst_d  = inst_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
`ifdef IF_LAST_HIT_EN
        lb_tag_d   = lb_tag_q;
        lb_data_d  = lb_data_q;
        lb_valid_d = lb_valid_q;
        hit_pend_d = 1'b0;
        if (hit_pend_q) begin
            inst_d  = lb_data_q;
            valid_d = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                mem_a_d = 32'd0;
                if (ce_i && !lb_hit) begin
                    addr_d  = pc_i;
                    mem_a_d = pc_i;
                    cnt_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = ADDR;
                end
`ifdef IF_LAST_HIT_EN
                hit_pend_d = ce_i && lb_hit;
`endif
            end
            ADDR: begin
                // RAM data lags mem_a by one cycle, so byte k arrives while cnt_q == k+1.
                if (cnt_q != 2'd0) cap_d = {mem_din, cap_q[23:8]};
                cnt_d = cnt_inc;
                if (cnt_q == 2'd3) begin
                    mem_a_d = 32'd0;
                    state_d = DRAIN;
                end else begin
                    mem_a_d = addr_q + {30'd0, cnt_inc};
                end
            end
            DRAIN: begin
                inst_d  = {mem_din, cap_q};
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef IF_LAST_HIT_EN
                lb_tag_d   = addr_q;
                lb_data_d  = {mem_din, cap_q};
                lb_valid_d = 1'b1;
`endif
            end
            default: begin
                mem_a_d = 32'd0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            mem_a_q <= 32'd0;
            inst_q  <= 32'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef IF_LAST_HIT_EN
            lb_valid_q <= 1'b0;
            hit_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_a_q <= mem_a_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef IF_LAST_HIT_EN
            lb_valid_q <= lb_valid_d;
            hit_pend_q <= hit_pend_d;
`endif
        end
    end

    // NOTE: datapath/storage registers skip reset; they are always written before being read.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        cap_q  <= cap_d;
`ifdef IF_LAST_HIT_EN
        lb_tag_q  <= lb_tag_d;
        lb_data_q <= lb_data_d;
`endif
    end

    assign mem_a        = mem_a_q;
    assign mem_wr       = 1'b0;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign busy_o       = busy_q;

endmodule
